// File: rtl/vga_layer_compositor.sv
// -----------------------------------------------------------------------------
// vga_layer_compositor
//
// Pixel compositor for the game display. Once per frame it latches the pipe,
// bird and score registers into shadow copies, so the scene cannot tear
// mid-frame. It hit-tests every pixel against NUM_PIPES pipe channels and the
// bird, then resolves layer priority through a two-stage pixel pipeline. It
// also reports whether the bird overlapped a pipe anywhere in the previous
// frame.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   pix_en            pixel strobe; every register advances only when high
//   active            active-video flag from the timing generator
//   screen_end        one-strobe frame boundary marker (shadow latch point)
//   hsync_in/vsync_in raw syncs from the timing generator
//   x, y              current pixel column / row
//   pipe_x            signed left edge per pipe channel (32 bits each)
//   pipe_bottom_top   top row of the lower pipe, per channel
//   pipe_gap          gap height, per channel
//   bird_top          bird top row
//   current_score     live score (any nonzero value selects game mode)
//   bg_color          background ROM data, aligned to stage 1
//   bird_color        bird ROM data, aligned to stage 1
//   ovl_hit           overlay coverage per layer, aligned to stage 1
//   ovl_color         overlay colour per layer, aligned to stage 1
//   rgb               composited pixel, blanked outside active video
//   hsync, vsync      syncs delayed to line up with rgb
//   game_mode         1 = game scene, 0 = splash; moves only at frame boundary
//   frame_collision   bird touched a pipe during the previous frame
// -----------------------------------------------------------------------------
module vga_layer_compositor #(
  parameter int              NUM_PIPES      = 4,
  parameter int              NUM_OVL        = 3,
  parameter int              BPC            = 12,
  parameter int              PIPE_WIDTH     = 57,
  parameter logic [BPC-1:0]  PIPE_COLOR     = 12'h3A3,
  parameter int              BIRD_LEFT_EDGE = 60,
  parameter int              BIRD_WIDTH     = 47,
  parameter int              BIRD_HEIGHT    = 33
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_en,
  input  logic                      active,
  input  logic                      screen_end,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
  input  logic [32*NUM_PIPES-1:0]   pipe_x,
  input  logic [32*NUM_PIPES-1:0]   pipe_bottom_top,
  input  logic [32*NUM_PIPES-1:0]   pipe_gap,
  input  logic [31:0]               bird_top,
  input  logic [31:0]               current_score,
  input  logic [BPC-1:0]            bg_color,
  input  logic [BPC-1:0]            bird_color,
  input  logic [NUM_OVL-1:0]        ovl_hit,
  input  logic [BPC*NUM_OVL-1:0]    ovl_color,
  output logic [BPC-1:0]            rgb,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      game_mode,
  output logic                      frame_collision
);

  localparam logic signed [32:0] PIPE_W_S  = 33'(PIPE_WIDTH);
  localparam logic signed [32:0] BIRD_X0_S = 33'(BIRD_LEFT_EDGE);
  localparam logic signed [32:0] BIRD_W_S  = 33'(BIRD_WIDTH);
  localparam logic signed [32:0] BIRD_H_S  = 33'(BIRD_HEIGHT);

  // Per-frame shadow copies of the game-object registers.
  logic signed [31:0] px_sh  [NUM_PIPES];
  logic signed [31:0] bt_sh  [NUM_PIPES];
  logic signed [31:0] gap_sh [NUM_PIPES];
  logic signed [31:0] bird_top_sh;
  logic        [31:0] score_sh;

  // Pipe hit test, 33-bit signed so off-screen edges never wrap.
  function automatic logic pipe_hit_f(
    input logic signed [31:0] px,
    input logic signed [31:0] bt,
    input logic signed [31:0] gap,
    input logic signed [32:0] xs,
    input logic signed [32:0] ys
  );
    logic signed [32:0] px_e, bt_e, gap_e;
    logic enabled, in_col, in_row;
    px_e    = $signed({px[31], px});
    bt_e    = $signed({bt[31], bt});
    gap_e   = $signed({gap[31], gap});
    enabled = (px != 32'sd0) || (bt != 32'sd0) || (gap != 32'sd0);
    in_col  = (xs >= px_e) && (xs < px_e + PIPE_W_S);
    in_row  = (ys < bt_e - gap_e) || (ys >= bt_e);
    return enabled && in_col && in_row;
  endfunction

  function automatic logic bird_hit_f(
    input logic signed [31:0] top,
    input logic signed [32:0] xs,
    input logic signed [32:0] ys
  );
    logic signed [32:0] top_e;
    top_e = $signed({top[31], top});
    return (xs >= BIRD_X0_S) && (xs < BIRD_X0_S + BIRD_W_S) &&
           (ys >= top_e) && (ys < top_e + BIRD_H_S);
  endfunction

  // Layer priority. Lower pipe / overlay index wins, so later writes override.
  function automatic logic [BPC-1:0] compose_f(
    input logic                   game,
    input logic [NUM_PIPES-1:0]   pipe_hit,
    input logic                   bird_hit,
    input logic [NUM_OVL-1:0]     oh,
    input logic [BPC*NUM_OVL-1:0] oc,
    input logic [BPC-1:0]         bg,
    input logic [BPC-1:0]         bird
  );
    logic [BPC-1:0] c;
    c = bg;
    if (game) begin
      if (bird_hit) c = bird;
      if (|pipe_hit) c = PIPE_COLOR;
      if (oh[0]) c = oc[BPC-1:0];
    end else begin
      for (int k = NUM_OVL - 1; k >= 0; k--) begin
        if (oh[k]) c = oc[BPC*k +: BPC];
      end
    end
    return c;
  endfunction

  // Stage 0: combinational hit tests against the shadow registers.
  logic signed [32:0]   xs_p0, ys_p0;
  logic [NUM_PIPES-1:0] pipe_hit_p0;
  logic                 bird_hit_p0;

  assign xs_p0 = $signed({23'd0, x});
  assign ys_p0 = $signed({24'd0, y});

  always_comb begin
    pipe_hit_p0 = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_hit_p0[i] = pipe_hit_f(px_sh[i], bt_sh[i], gap_sh[i], xs_p0, ys_p0);
    end
    bird_hit_p0 = bird_hit_f(bird_top_sh, xs_p0, ys_p0);
  end

  // game_mode is a pure function of the shadow registers, which only move at
  // screen_end, so it is equivalent to registering the OR of the inputs there.
  always_comb begin
    game_mode = (bird_top_sh != 32'sd0) || (score_sh != 32'd0);
    for (int i = 0; i < NUM_PIPES; i++) begin
      game_mode = game_mode || (px_sh[i] != 32'sd0) ||
                  (bt_sh[i] != 32'sd0) || (gap_sh[i] != 32'sd0);
    end
  end

  // Stage 1 / stage 2 registers.
  logic [NUM_PIPES-1:0] pipe_hit_p1;
  logic                 bird_hit_p1;
  logic                 vld_p1;
  logic                 hsync_p1, vsync_p1;
  logic [BPC-1:0]       rgb_p2;
  logic                 hsync_p2, vsync_p2;
  logic                 coll_sticky;
  logic                 coll_set;

  assign coll_set = game_mode && vld_p1 && bird_hit_p1 && (|pipe_hit_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_sh[i]  <= '0;
        bt_sh[i]  <= '0;
        gap_sh[i] <= '0;
      end
      bird_top_sh     <= '0;
      score_sh        <= '0;
      pipe_hit_p1     <= '0;
      bird_hit_p1     <= 1'b0;
      vld_p1          <= 1'b0;
      hsync_p1        <= 1'b1;
      vsync_p1        <= 1'b1;
      rgb_p2          <= '0;
      hsync_p2        <= 1'b1;
      vsync_p2        <= 1'b1;
      coll_sticky     <= 1'b0;
      frame_collision <= 1'b0;
    end else if (pix_en) begin
      // Stage 0 -> 1: capture hit vectors alongside active and syncs.
      pipe_hit_p1 <= pipe_hit_p0;
      bird_hit_p1 <= bird_hit_p0;
      vld_p1      <= active;
      hsync_p1    <= hsync_in;
      vsync_p1    <= vsync_in;

      // Stage 1 -> 2: resolve priority against the ROM data, blank when idle.
      rgb_p2   <= vld_p1 ? compose_f(game_mode, pipe_hit_p1, bird_hit_p1, ovl_hit,
                                     ovl_color, bg_color, bird_color) : '0;
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;

      if (screen_end) begin
        // A hit on the last pixel of the frame still counts for this frame.
        frame_collision <= coll_sticky || coll_set;
        coll_sticky     <= 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
          px_sh[i]  <= $signed(pipe_x[32*i +: 32]);
          bt_sh[i]  <= $signed(pipe_bottom_top[32*i +: 32]);
          gap_sh[i] <= $signed(pipe_gap[32*i +: 32]);
        end
        bird_top_sh <= $signed(bird_top);
        score_sh    <= current_score;
      end else if (coll_set) begin
        coll_sticky <= 1'b1;
      end
    end
  end

  assign rgb   = rgb_p2;
  assign hsync = hsync_p2;
  assign vsync = vsync_p2;

endmodule

// File: tb/tb_vga_layer_compositor.sv
module tb_vga_layer_compositor;
  localparam int NP = 4;
  localparam int NO = 3;
  localparam int BPC = 12;
  localparam int PW = 57;
  localparam logic [11:0] PIPE_COLOR = 12'h3A3;
  localparam int BX0 = 60;
  localparam int BW = 47;
  localparam int BH = 33;

  logic clk = 1'b0;
  logic reset, pix_en, active, screen_end, hsync_in, vsync_in;
  logic [9:0] x;
  logic [8:0] y;
  logic [32*NP-1:0] pipe_x, pipe_bottom_top, pipe_gap;
  logic [31:0] bird_top, current_score;
  logic [BPC-1:0] bg_color, bird_color;
  logic [NO-1:0] ovl_hit;
  logic [BPC*NO-1:0] ovl_color;
  logic [BPC-1:0] rgb;
  logic hsync, vsync, game_mode, frame_collision;

  vga_layer_compositor dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .active(active),
    .screen_end(screen_end), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .pipe_x(pipe_x), .pipe_bottom_top(pipe_bottom_top),
    .pipe_gap(pipe_gap), .bird_top(bird_top), .current_score(current_score),
    .bg_color(bg_color), .bird_color(bird_color), .ovl_hit(ovl_hit),
    .ovl_color(ovl_color), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .game_mode(game_mode), .frame_collision(frame_collision)
  );

  always #5 clk = ~clk;

  int cmp_count = 0;
  int fail_count = 0;

  // Reference model: frame-level scene state plus the pixel waiting in flight.
  int          sh_px[NP], sh_bt[NP], sh_gap[NP];
  int          sh_bird;
  logic [31:0] sh_score;
  bit          m_game, m_sticky, exp_fc;
  bit          p_act, p_any, p_bird, p_hs, p_vs;
  logic [11:0] exp_rgb;
  bit          exp_hs, exp_vs;

  function automatic bit m_pipe_hit(int i, int xx, int yy);
    longint px = sh_px[i];
    longint bt = sh_bt[i];
    longint gp = sh_gap[i];
    if (sh_px[i] == 0 && sh_bt[i] == 0 && sh_gap[i] == 0) return 1'b0;
    return (xx >= px) && (xx < px + PW) && ((yy < bt - gp) || (yy >= bt));
  endfunction

  function automatic bit m_bird_hit(int xx, int yy);
    longint bb = sh_bird;
    return (xx >= BX0) && (xx < BX0 + BW) && (yy >= bb) && (yy < bb + BH);
  endfunction

  function automatic logic [11:0] m_color();
    if (!p_act) return 12'h000;
    if (m_game) begin
      if (ovl_hit[0]) return ovl_color[11:0];
      if (p_any) return PIPE_COLOR;
      if (p_bird) return bird_color;
      return bg_color;
    end
    for (int k = 0; k < NO; k++) if (ovl_hit[k]) return ovl_color[12*k +: 12];
    return bg_color;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      sh_px[i] = 0; sh_bt[i] = 0; sh_gap[i] = 0;
    end
    sh_bird = 0; sh_score = 0; m_game = 0; m_sticky = 0; exp_fc = 0;
    p_act = 0; p_any = 0; p_bird = 0; p_hs = 1; p_vs = 1;
    exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1;
  endtask

  // One pixel strobe: advance the model, then pulse pix_en for 1 of 4 clocks.
  task automatic strobe(input bit se);
    bit coll, c_any;
    exp_rgb = m_color();
    exp_hs = p_hs;
    exp_vs = p_vs;
    coll = m_game && p_act && p_bird && p_any;
    c_any = 1'b0;
    for (int i = 0; i < NP; i++) if (m_pipe_hit(i, int'(x), int'(y))) c_any = 1'b1;
    p_bird = m_bird_hit(int'(x), int'(y));
    p_any = c_any;
    p_act = active;
    p_hs = hsync_in;
    p_vs = vsync_in;
    if (se) begin
      exp_fc = m_sticky || coll;
      m_sticky = 1'b0;
      for (int i = 0; i < NP; i++) begin
        sh_px[i]  = pipe_x[32*i +: 32];
        sh_bt[i]  = pipe_bottom_top[32*i +: 32];
        sh_gap[i] = pipe_gap[32*i +: 32];
      end
      sh_bird = bird_top;
      sh_score = current_score;
      m_game = (sh_bird != 0) || (sh_score != 0);
      for (int i = 0; i < NP; i++)
        if (sh_px[i] != 0 || sh_bt[i] != 0 || sh_gap[i] != 0) m_game = 1'b1;
    end else if (coll) begin
      m_sticky = 1'b1;
    end
    screen_end = se;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    screen_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic show(input int xx, input int yy);
    x = 10'(xx); y = 9'(yy); active = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    strobe(1'b0);
    strobe(1'b0);
  endtask

  task automatic frame_end();
    active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    strobe(1'b1);
  endtask

  task automatic clear_cfg();
    pipe_x = '0; pipe_bottom_top = '0; pipe_gap = '0;
    bird_top = 32'd0; current_score = 32'd0;
  endtask

  task automatic set_pipe(input int i, input int px, input int bt, input int gp);
    pipe_x[32*i +: 32] = px;
    pipe_bottom_top[32*i +: 32] = bt;
    pipe_gap[32*i +: 32] = gp;
  endtask

  task automatic test_reset();
    cmp_count++; if (rgb !== 12'h000) begin fail_count++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    cmp_count++; if (hsync !== 1'b1) begin fail_count++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    cmp_count++; if (vsync !== 1'b1) begin fail_count++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    cmp_count++; if (game_mode !== 1'b0) begin fail_count++; $display("FAIL reset_game_mode: got %b expected 0", game_mode); end
    cmp_count++; if (frame_collision !== 1'b0) begin fail_count++; $display("FAIL reset_frame_collision: got %b expected 0", frame_collision); end
  endtask

  task automatic test_latency();
    clear_cfg(); bird_top = 32'd300; bg_color = 12'h123; ovl_hit = '0;
    frame_end();
    cmp_count++; if (game_mode !== 1'b1) begin fail_count++; $display("FAIL lat_game_mode: got %b expected 1", game_mode); end
    x = 10'd100; y = 9'd100; active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    strobe(1'b0);
    cmp_count++; if (rgb !== 12'h000) begin fail_count++; $display("FAIL lat_rgb_1: got %h expected 000", rgb); end
    cmp_count++; if (hsync !== 1'b1) begin fail_count++; $display("FAIL lat_hsync_1: got %b expected 1", hsync); end
    active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    strobe(1'b0);
    cmp_count++; if (rgb !== 12'h123) begin fail_count++; $display("FAIL lat_rgb_2: got %h expected 123", rgb); end
    cmp_count++; if (hsync !== 1'b0) begin fail_count++; $display("FAIL lat_hsync_2: got %b expected 0", hsync); end
    cmp_count++; if (vsync !== 1'b0) begin fail_count++; $display("FAIL lat_vsync_2: got %b expected 0", vsync); end
    strobe(1'b0);
    cmp_count++; if (rgb !== 12'h000) begin fail_count++; $display("FAIL lat_rgb_3: got %h expected 000", rgb); end
    cmp_count++; if (hsync !== 1'b1) begin fail_count++; $display("FAIL lat_hsync_3: got %b expected 1", hsync); end
  endtask

  task automatic test_shadow();
    int xa[4] = '{79, 80, 136, 137};
    logic [11:0] ea[4] = '{12'h123, PIPE_COLOR, PIPE_COLOR, 12'h123};
    int xb[2] = '{80, 300};
    logic [11:0] eb[2] = '{PIPE_COLOR, 12'h123};
    int xc[4] = '{80, 300, 356, 357};
    logic [11:0] ec[4] = '{12'h123, PIPE_COLOR, PIPE_COLOR, 12'h123};
    clear_cfg(); set_pipe(0, 80, 200, 100); bird_top = 32'd300; bg_color = 12'h123;
    frame_end();
    for (int i = 0; i < 4; i++) begin
      show(xa[i], 50);
      cmp_count++; if (rgb !== ea[i]) begin fail_count++; $display("FAIL shadow_before x=%0d: got %h expected %h", xa[i], rgb, ea[i]); end
    end
    set_pipe(0, 300, 200, 100);
    for (int i = 0; i < 2; i++) begin
      show(xb[i], 50);
      cmp_count++; if (rgb !== eb[i]) begin fail_count++; $display("FAIL shadow_midframe x=%0d: got %h expected %h", xb[i], rgb, eb[i]); end
    end
    frame_end();
    for (int i = 0; i < 4; i++) begin
      show(xc[i], 50);
      cmp_count++; if (rgb !== ec[i]) begin fail_count++; $display("FAIL shadow_after x=%0d: got %h expected %h", xc[i], rgb, ec[i]); end
    end
  endtask

  task automatic test_priority();
    logic [2:0]  oh[5] = '{3'b000, 3'b010, 3'b001, 3'b000, 3'b000};
    int          px[5] = '{70, 70, 70, 70, 30};
    int          py[5] = '{95, 95, 95, 110, 110};
    logic [11:0] ex[5] = '{PIPE_COLOR, PIPE_COLOR, 12'hA01, 12'h0F0, 12'h123};
    clear_cfg(); set_pipe(0, 50, 200, 100); bird_top = 32'd90;
    bird_color = 12'h0F0; bg_color = 12'h123;
    frame_end();
    for (int i = 0; i < 5; i++) begin
      ovl_hit = oh[i];
      show(px[i], py[i]);
      cmp_count++; if (rgb !== ex[i]) begin fail_count++; $display("FAIL priority case %0d: got %h expected %h", i, rgb, ex[i]); end
    end
    ovl_hit = '0;
  endtask

  task automatic test_splash();
    logic [2:0]  oh[4] = '{3'b110, 3'b100, 3'b111, 3'b000};
    logic [11:0] ex[4] = '{12'hB02, 12'hC03, 12'hA01, 12'h123};
    clear_cfg(); bg_color = 12'h123;
    frame_end();
    cmp_count++; if (game_mode !== 1'b0) begin fail_count++; $display("FAIL splash_game_mode: got %b expected 0", game_mode); end
    for (int i = 0; i < 4; i++) begin
      ovl_hit = oh[i];
      show(70, 95);
      cmp_count++; if (rgb !== ex[i]) begin fail_count++; $display("FAIL splash case %0d: got %h expected %h", i, rgb, ex[i]); end
    end
    ovl_hit = '0;
  endtask

  task automatic test_negative_x();
    int          px[4] = '{0, 36, 37, 10};
    int          py[4] = '{50, 50, 50, 150};
    logic [11:0] ex[4] = '{PIPE_COLOR, PIPE_COLOR, 12'h123, 12'h123};
    clear_cfg(); set_pipe(1, -20, 200, 100); bird_top = 32'd300; bg_color = 12'h123;
    frame_end();
    for (int i = 0; i < 4; i++) begin
      show(px[i], py[i]);
      cmp_count++; if (rgb !== ex[i]) begin fail_count++; $display("FAIL negx (%0d,%0d): got %h expected %h", px[i], py[i], rgb, ex[i]); end
    end
  endtask

  task automatic test_collision();
    clear_cfg(); set_pipe(0, 50, 200, 100); bird_top = 32'd90; bg_color = 12'h123;
    frame_end();
    show(300, 300);
    frame_end();
    cmp_count++; if (frame_collision !== 1'b0) begin fail_count++; $display("FAIL coll_clean: got %b expected 0", frame_collision); end
    show(70, 95);
    show(300, 300);
    frame_end();
    cmp_count++; if (frame_collision !== 1'b1) begin fail_count++; $display("FAIL coll_frame_n1_start: got %b expected 1", frame_collision); end
    show(300, 300);
    cmp_count++; if (frame_collision !== 1'b1) begin fail_count++; $display("FAIL coll_frame_n1_mid: got %b expected 1", frame_collision); end
    show(10, 10);
    cmp_count++; if (frame_collision !== 1'b1) begin fail_count++; $display("FAIL coll_frame_n1_late: got %b expected 1", frame_collision); end
    frame_end();
    cmp_count++; if (frame_collision !== 1'b0) begin fail_count++; $display("FAIL coll_frame_n2: got %b expected 0", frame_collision); end
    x = 10'd70; y = 9'd95; active = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    strobe(1'b0);
    frame_end();
    cmp_count++; if (frame_collision !== 1'b1) begin fail_count++; $display("FAIL coll_same_cycle: got %b expected 1", frame_collision); end
    frame_end();
    cmp_count++; if (frame_collision !== 1'b0) begin fail_count++; $display("FAIL coll_after_same_cycle: got %b expected 0", frame_collision); end
  endtask

  task automatic test_reset_midframe();
    clear_cfg(); set_pipe(0, 50, 200, 100); bird_top = 32'd90; bg_color = 12'h123;
    frame_end();
    show(70, 95);
    frame_end();
    x = 10'd70; y = 9'd240; active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
    strobe(1'b0);
    strobe(1'b0);
    cmp_count++; if (rgb !== PIPE_COLOR) begin fail_count++; $display("FAIL rmid_pre_rgb: got %h expected %h", rgb, PIPE_COLOR); end
    cmp_count++; if (hsync !== 1'b0) begin fail_count++; $display("FAIL rmid_pre_hsync: got %b expected 0", hsync); end
    cmp_count++; if (frame_collision !== 1'b1) begin fail_count++; $display("FAIL rmid_pre_fc: got %b expected 1", frame_collision); end
    do_reset();
    cmp_count++; if (rgb !== 12'h000) begin fail_count++; $display("FAIL rmid_rgb: got %h expected 000", rgb); end
    cmp_count++; if (hsync !== 1'b1) begin fail_count++; $display("FAIL rmid_hsync: got %b expected 1", hsync); end
    cmp_count++; if (game_mode !== 1'b0) begin fail_count++; $display("FAIL rmid_game_mode: got %b expected 0", game_mode); end
    cmp_count++; if (frame_collision !== 1'b0) begin fail_count++; $display("FAIL rmid_fc: got %b expected 0", frame_collision); end
    show(70, 240);
    cmp_count++; if (rgb !== 12'h123) begin fail_count++; $display("FAIL rmid_splash_rgb: got %h expected 123", rgb); end
    cmp_count++; if (game_mode !== 1'b0) begin fail_count++; $display("FAIL rmid_splash_mode: got %b expected 0", game_mode); end
    clear_cfg();
    frame_end();
    cmp_count++; if (game_mode !== 1'b0) begin fail_count++; $display("FAIL rmid_zero_latch: got %b expected 0", game_mode); end
    bird_top = 32'd5;
    frame_end();
    cmp_count++; if (game_mode !== 1'b1) begin fail_count++; $display("FAIL rmid_nonzero_latch: got %b expected 1", game_mode); end
  endtask

  task automatic random_cfg();
    clear_cfg();
    if ($urandom_range(0, 4) == 0) return;
    for (int i = 0; i < NP; i++) begin
      if ($urandom_range(0, 3) != 0)
        set_pipe(i, int'($urandom_range(0, 700)) - 60, int'($urandom_range(0, 480)),
                 int'($urandom_range(0, 160)));
    end
    bird_top = $urandom_range(0, 470);
    current_score = $urandom;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 5; f++) begin
      random_cfg();
      frame_end();
      cmp_count++; if (game_mode !== m_game) begin fail_count++; $display("FAIL rnd_game_mode f=%0d: got %b expected %b", f, game_mode, m_game); end
      cmp_count++; if (frame_collision !== exp_fc) begin fail_count++; $display("FAIL rnd_fc_boundary f=%0d: got %b expected %b", f, frame_collision, exp_fc); end
      for (int n = 0; n < 80; n++) begin
        if ($urandom_range(0, 9) < 3) begin
          x = 10'(BX0 + int'($urandom_range(0, BW - 1)));
          y = 9'(sh_bird + int'($urandom_range(0, BH - 1)));
        end else begin
          x = 10'($urandom_range(0, 639));
          y = 9'($urandom_range(0, 479));
        end
        active = ($urandom_range(0, 7) != 0);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        bg_color = 12'($urandom);
        bird_color = 12'($urandom);
        ovl_hit = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        ovl_color = 36'({$urandom, $urandom});
        strobe(1'b0);
        cmp_count++; if (rgb !== exp_rgb) begin fail_count++; $display("FAIL rnd_rgb f=%0d n=%0d: got %h expected %h", f, n, rgb, exp_rgb); end
        cmp_count++; if (hsync !== exp_hs || vsync !== exp_vs) begin fail_count++; $display("FAIL rnd_sync f=%0d n=%0d: got %b%b expected %b%b", f, n, hsync, vsync, exp_hs, exp_vs); end
        cmp_count++; if (frame_collision !== exp_fc) begin fail_count++; $display("FAIL rnd_fc f=%0d n=%0d: got %b expected %b", f, n, frame_collision, exp_fc); end
      end
    end
    ovl_hit = '0;
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; active = 1'b0; screen_end = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; x = '0; y = '0;
    clear_cfg();
    bg_color = 12'h123; bird_color = 12'h0F0; ovl_hit = '0;
    ovl_color = {12'hC03, 12'hB02, 12'hA01};
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    test_reset();
    test_latency();
    test_shadow();
    test_priority();
    test_splash();
    test_negative_x();
    test_collision();
    test_reset_midframe();
    ovl_color = {12'hC03, 12'hB02, 12'hA01};
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised pixel compositor that succeeds the fixed four-pipe VGA controller mux.
- Latches all game-object registers once per frame to prevent tearing, and computes pipe and bird hit tests for NUM_PIPES channels.
- Resolves layer priority through a registered pixel pipeline and reports per-frame bird/pipe pixel collision.
- Sits between the VGA timing generator, the image ROMs and the VGA pins.

Parameters:
- NUM_PIPES, 4, number of pipe channels (1..8).
- NUM_OVL, 3, number of overlay text layers; index 0 is the score.
- BPC, 12, colour bits per pixel.
- PIPE_WIDTH, 57, pipe width in pixels.
- PIPE_COLOR, 12'h3A3, solid pipe fill colour.
- BIRD_LEFT_EDGE, 60, fixed bird left x.
- BIRD_WIDTH, 47, bird width in pixels.
- BIRD_HEIGHT, 33, bird height in pixels.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high.
- pix_en  in  1  25 MHz pixel strobe; the pipeline advances only when high.
- active  in  1  timing-generator active-video flag.
- screen_end  in  1  high for one pix_en cycle between frames.
- hsync_in  in  1  raw horizontal sync.
- vsync_in  in  1  raw vertical sync.
- x  in  10  pixel column.
- y  in  9  pixel row.
- pipe_x  in  32*NUM_PIPES  signed left edge per pipe.
- pipe_bottom_top  in  32*NUM_PIPES  top row of the lower pipe.
- pipe_gap  in  32*NUM_PIPES  gap height.
- bird_top  in  32  bird top row.
- current_score  in  32  live score.
- bg_color  in  BPC  background ROM data, aligned to stage 1.
- bird_color  in  BPC  bird ROM data, aligned to stage 1.
- ovl_hit  in  NUM_OVL  overlay coverage, aligned to stage 1.
- ovl_color  in  BPC*NUM_OVL  overlay colours, aligned to stage 1.
- rgb  out  BPC  composited pixel.
- hsync  out  1  sync delayed to match rgb.
- vsync  out  1  sync delayed to match rgb.
- game_mode  out  1  1 = game, 0 = splash; changes only at a frame boundary.
- frame_collision  out  1  bird overlapped a pipe in the previous frame.

Behaviour:
- Reset:
  - All shadow registers are 0.
  - game_mode=0, rgb=0, hsync=1, vsync=1, frame_collision=0.
  - Collision sticky bit and pipeline valid bits are cleared.
  - Reset is honoured mid-frame; the pipeline flushes to the reset values in the next clk.
- Shadow latch: on clk where pix_en&screen_end, copy all pipe_*, bird_top and current_score into shadow registers. Hit tests use shadow values only, so mid-frame input changes have no visible effect.
- Mode: on the same edge, game_mode <= OR-reduction of all shadow-bound values being nonzero (computed from the incoming values).
- Pipe channel i is disabled when its x, bottom_top and gap are all 0. A disabled channel never hits.
- Pipe hit, with all comparisons signed 33-bit so there is no overflow or wrap:
  - x_s >= px and x_s < px+PIPE_WIDTH; px may be negative, so partly off-left pipes draw their remainder.
  - and either y < bt-gap or y >= bt.
- Bird hit: x in [BIRD_LEFT_EDGE, +BIRD_WIDTH) and y in [bird_top, bird_top+BIRD_HEIGHT).
- Pipeline, advancing per pix_en:
  - Stage 1 registers the hit vectors, active and syncs.
  - Stage 2 registers rgb and the syncs.
  - Latency is exactly 2 pix_en strobes from x/y to rgb; syncs are delayed identically.
- Priority in game mode: ovl[0] > pipe[0] > … > pipe[NUM_PIPES-1] > bird > bg.
- Priority in splash mode: ovl[0] > … > ovl[NUM_OVL-1] > bg. Pipes, bird and overlays 1..N-1 are ignored in game mode except ovl[0].
- Blanking: stage-2 rgb = 0 whenever the delayed active is 0.
- Collision:
  - The sticky bit sets when game_mode and stage-1 active and bird hit and any pipe hit.
  - At screen_end: frame_collision <= sticky (including a same-cycle set), then sticky clears.
  - frame_collision holds for a full frame.
- When pix_en=0, all state holds.

Test Plan:
- Latency: reset, enable pix_en every 4th clk, game_mode=1, x=100,y=100 over background 12'h123. Required: rgb=12'h123 exactly 2 strobes later, with hsync/vsync shifted the same amount.
- Shadow: pipe_x[0]=80 is latched; change it to 300 mid-frame. Required: the pipe still renders at x=80..136 until after the next screen_end, then at 300..356.
- Priority: pipe0 bottom_top=200, gap=100, bird_top=90, pixel (70,95). Required: rgb=PIPE_COLOR; with ovl_hit[0]=1, rgb=ovl_color[0].
- Negative x: pipe_x[1]=-20. Required: columns 0..36 show the pipe and column 37 shows background. With all fields of channel 2 = 0, channel 2 never draws.
- Collision: bird overlaps pipe0 for one pixel in frame N. Required: frame_collision=1 throughout frame N+1, then 0 in frame N+2 with no overlap.
- Reset mid-frame: assert reset at y=240. Required: the next clk gives rgb=0, game_mode=0, frame_collision=0; splash mode persists until a nonzero latch.
